demux_merge4: RTL

- Downstream collector for the 4-way demultiplexer: takes the four N-bit demux outputs as independent valid/ready channels and merges them onto one registered output stream.
- Each channel has a one-entry holding register. A round-robin arbiter selects the next occupied channel.
- Every output word is tagged with its 2-bit channel index, matching the demux select encoding: 2'b00 = channel 1 … 2'b11 = channel 4.

---
 rtl/demux_merge4.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/demux_merge4.sv
// demux_merge4: merges four valid/ready channels, each with a one-entry holding register, into one registered, channel-tagged output stream.
// Define DEMUX_MERGE4_XFER_CNT_EN to build the 16-bit output transfer counter; otherwise xfer_cnt is tied to zero.
module demux_merge4 #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i1,
  input  logic [N-1:0] i2,
  input  logic [N-1:0] i3,
  input  logic [N-1:0] i4,
  input  logic         v1,
  input  logic         v2,
  input  logic         v3,
  input  logic         v4,
  output logic         r1,
  output logic         r2,
  output logic         r3,
  output logic         r4,
  output logic [N-1:0] out,
  output logic [1:0]   out_ch,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  xfer_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_e;

  logic [3:0][N-1:0] in_data;
  logic [3:0]        in_valid;
  logic [3:0]        rdy;
  logic [3:0]        full;
  logic [3:0][N-1:0] hold_all;

  logic              alive_q, alive_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [N-1:0]      out_q, out_d;
  logic [1:0]        out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;

  logic              load;
  logic              grant_valid;
  logic [1:0]        grant_idx;
  logic [1:0]        idx;

  assign in_data  = {i4, i3, i2, i1};
  assign in_valid = {v4, v3, v2, v1};
  assign {r4, r3, r2, r1} = rdy;

  // Scanning offsets from high to low lets the nearest full channel win.
  always_comb begin
    load        = ~out_valid_q | out_ready;
    grant_valid = 1'b0;
    grant_idx   = ptr_q;
    idx         = 2'd0;
    for (int off = 3; off >= 0; off--) begin
      idx = ptr_q + off[1:0];
      if (full[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      ch_state_e    state_q, state_d;
      logic [N-1:0] hold_q, hold_d;

      // Ready is held low while in reset and for the first edge after it.
      assign rdy[gi]      = alive_q & (state_q == EMPTY);
      assign full[gi]     = (state_q == FULL);
      assign hold_all[gi] = hold_q;

      always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (rdy[gi] && in_valid[gi]) begin
          state_d = FULL;
          hold_d  = in_data[gi];
        end else if (load && grant_valid && (grant_idx == 2'(gi))) begin
          state_d = EMPTY;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= EMPTY;
          hold_q  <= '0;
        end else begin
          state_q <= state_d;
          hold_q  <= hold_d;
        end
      end
    end
  endgenerate

  always_comb begin
    alive_d     = 1'b1;
    ptr_d       = ptr_q;
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (load) begin
      if (grant_valid) begin
        out_d       = hold_all[grant_idx];
        out_ch_d    = grant_idx;
        out_valid_d = 1'b1;
        ptr_d       = grant_idx + 2'd1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alive_q     <= 1'b0;
      ptr_q       <= 2'd0;
      out_q       <= '0;
      out_ch_q    <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      alive_q     <= alive_d;
      ptr_q       <= ptr_d;
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

`ifdef DEMUX_MERGE4_XFER_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + {15'd0, out_valid_q & out_ready};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;
`else
  assign xfer_cnt = 16'h0000;
`endif

endmodule
